// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit processor: instruction format, opcodes
// and the fetch-stage FSM state type.
package cpu_pkg;

  localparam int INSTR_W = 8;
  localparam int OPC_MSB = 7;
  localparam int OPC_LSB = 5;
  localparam int OPC_W   = OPC_MSB - OPC_LSB + 1;

  localparam logic [OPC_W-1:0] OP_LW   = 3'b000;
  localparam logic [OPC_W-1:0] OP_SW   = 3'b001;
  localparam logic [OPC_W-1:0] OP_ADD  = 3'b010;
  localparam logic [OPC_W-1:0] OP_ADDI = 3'b011;
  localparam logic [OPC_W-1:0] OP_SUB  = 3'b100;
  localparam logic [OPC_W-1:0] OP_JMP  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_DROP = 2'b10
  } fetch_state_t;

  function automatic logic [OPC_W-1:0] opcode_of(input logic [INSTR_W-1:0] ins);
    return ins[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/fetch_buf.sv
// DEPTH-entry FIFO for fetched {pc, instr} entries. Entries shift toward
// slot 0 on pop, so the head is always slot 0 (works down to DEPTH=1).
module fetch_buf
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 16,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [W-1:0]     din,
  output logic [CNT_W-1:0] count,
  output logic [W-1:0]     head
);

  logic [W-1:0]     mem_r [DEPTH];
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] wr_idx_s;

  // A simultaneous pop shifts everything down, so the write lands one slot lower
  assign wr_idx_s = count_r - CNT_W'(pop);

  // Storage and occupancy; flush only clears the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {W{1'b0}};
      end
    end else if (flush) begin
      count_r <= {CNT_W{1'b0}};
    end else begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        if (pop) begin
          mem_r[i] <= mem_r[i+1];
        end
      end
      for (int i = 0; i < DEPTH; i++) begin
        if (push && (wr_idx_s == CNT_W'(i))) begin
          mem_r[i] <= din;
        end
      end
      count_r <= count_r + CNT_W'(push) - CNT_W'(pop);
    end
  end

  assign count = count_r;
  assign head  = mem_r[0];

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: pc, single-outstanding imem requests, fetch buffer
// and jump redirect. FETCH_PREFETCH_BUF_EN selects a 2-entry buffer (else 1).
module instr_fetch
  import cpu_pkg::*;
#(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               jump_en,
  input  logic [PC_W-1:0]    jump_target,
  input  logic               stall,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    instr_pc,
  output logic               instr_valid
);

`ifdef FETCH_PREFETCH_BUF_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int ENT_W = PC_W + INSTR_W;

  fetch_state_t     state_r, state_nxt_s;
  logic [PC_W-1:0]  pc_r, pc_nxt_s, req_pc_r;
  logic             push_s, pop_s, issue_s;
  logic [CNT_W-1:0] count_s;
  logic [CNT_W:0]   count_next_s;
  logic [ENT_W-1:0] head_s;

  fetch_buf #(
    .DEPTH (DEPTH),
    .W     (ENT_W),
    .CNT_W (CNT_W)
  ) u_buf (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .pop   (pop_s),
    .flush (jump_en),
    .din   ({req_pc_r, imem_rdata}),
    .count (count_s),
    .head  (head_s)
  );

  // Issue decision, next state and next pc; a jump overrides push, pop and issue
  always_comb begin
    state_nxt_s  = state_r;
    pc_nxt_s     = pc_r;
    push_s       = (state_r == S_WAIT) && imem_valid && !jump_en;
    pop_s        = (count_s != {CNT_W{1'b0}}) && !stall && !jump_en;
    count_next_s = {1'b0, count_s} + (CNT_W+1)'(push_s) - (CNT_W+1)'(pop_s);
    issue_s      = rst_n && !jump_en && (count_next_s < (CNT_W+1)'(DEPTH)) &&
                   ((state_r == S_IDLE) || ((state_r == S_WAIT) && imem_valid));
    case (state_r)
      S_IDLE: begin
        if (issue_s) state_nxt_s = S_WAIT;
        else         state_nxt_s = S_IDLE;
      end
      S_WAIT: begin
        if (jump_en)         state_nxt_s = imem_valid ? S_IDLE : S_DROP;
        else if (imem_valid) state_nxt_s = issue_s ? S_WAIT : S_IDLE;
        else                 state_nxt_s = S_WAIT;
      end
      S_DROP: begin
        if (imem_valid) state_nxt_s = S_IDLE;
        else            state_nxt_s = S_DROP;
      end
      default: state_nxt_s = S_IDLE;
    endcase
    if (jump_en)      pc_nxt_s = jump_target;
    else if (issue_s) pc_nxt_s = pc_r + {{(PC_W-1){1'b0}}, 1'b1};
    else              pc_nxt_s = pc_r;
  end

  // State, pc, and the address of the outstanding request (tagged on push)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= S_IDLE;
      pc_r     <= RESET_PC;
      req_pc_r <= RESET_PC;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (issue_s) req_pc_r <= pc_r;
    end
  end

  // Head of buffer, forced to zero when empty
  always_comb begin
    if (count_s != {CNT_W{1'b0}}) begin
      instr_valid = 1'b1;
      instr       = head_s[INSTR_W-1:0];
      instr_pc    = head_s[ENT_W-1:INSTR_W];
    end else begin
      instr_valid = 1'b0;
      instr       = {INSTR_W{1'b0}};
      instr_pc    = {PC_W{1'b0}};
    end
  end

  assign imem_req  = issue_s;
  assign imem_addr = pc_r;

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage for the 8-bit processor.
- Holds the program counter and issues single-outstanding read requests to instruction memory.
- Buffers the returned 8-bit instructions and presents them, with their PC, to the decode/control stage, which consumes opcode bits [7:5].
- Accepts jump redirects from the control path and flushes in-flight and buffered instructions.

## Interface
Parameters:
- PC_W, 8, program counter / instruction address width
- RESET_PC, 0, PC value loaded on reset

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- imem_req  output  1  read request, valid for one cycle per issue
- imem_addr  output  PC_W  address for imem_req; equals current pc
- imem_valid  input  1  read data valid; one pulse per issued request, at least 1 cycle after issue
- imem_rdata  input  8  instruction word, sampled when imem_valid=1
- jump_en  input  1  redirect request from control path
- jump_target  input  PC_W  new pc when jump_en=1
- stall  input  1  downstream not accepting this cycle
- instr  output  8  head instruction; 8'h00 when instr_valid=0
- instr_pc  output  PC_W  address of instr; 0 when instr_valid=0
- instr_valid  output  1  buffer non-empty

## Operation
- pc register:
  - Loads RESET_PC on reset.
  - Increments by 1 on each issued request, modulo 2^PC_W (0xFF wraps to 0x00).
- Buffer:
  - FIFO of {pc, instr} entries, DEPTH entries (see Configuration).
  - Pop when instr_valid && !stall.
  - Push on accepted imem_valid.
- At most one outstanding request.
- FSM states:
  - S_IDLE (reset state): no request outstanding.
  - S_WAIT: request outstanding.
  - S_DROP: outstanding response must be discarded.
- Issue rule: imem_req = !jump_en && (count_next + 1 <= DEPTH) && (state==S_IDLE || (state==S_WAIT && imem_valid)).
  - count_next is occupancy after this cycle's push/pop.
- Transitions:
  - S_IDLE: issue -> S_WAIT; else stay.
  - S_WAIT:
    - imem_valid -> push, then S_WAIT if a back-to-back issue occurs, else S_IDLE.
    - jump_en && !imem_valid -> S_DROP.
    - jump_en && imem_valid -> data discarded, S_IDLE.
  - S_DROP: imem_valid -> discard, S_IDLE. jump_en here updates pc only.
- jump_en, highest priority:
  - Buffer flushed (count=0).
  - pc <= jump_target.
  - No push and no issue that cycle.
  - A pop in the same cycle is ignored.
- imem_valid in S_IDLE is a protocol error and is ignored.
- stall with an empty buffer has no effect. Full buffer stops issuing; pc holds.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, instr=0, instr_pc=0, instr_valid=0, state=S_IDLE, count=0.
- First cycle after rst_n rises: imem_req=1, imem_addr=RESET_PC.
- Response latency L cycles (imem_valid L cycles after issue) gives instr_valid L+1 cycles after issue.
- With L=1, DEPTH=2, no stall: sustained one instruction per cycle.
- Redirect: instr_valid=0 the cycle after jump_en. The first fetch of jump_target issues that same next cycle, or after the dropped response arrives if in S_DROP.
- rst_n assertion mid-request: all state cleared immediately. A later stray imem_valid is ignored (S_IDLE).

## Configuration
- Macro FETCH_PREFETCH_BUF_EN.
  - Defined: DEPTH=2, giving back-to-back issue and full throughput under L=1.
  - Undefined: DEPTH=1, a single holding register. A new issue is allowed only when that register will be empty at cycle end, so throughput is at most one per 2 cycles with L=1.
- Interface is identical in both builds.

## Structure
- Shared package cpu_pkg holds:
  - INSTR_W=8
  - opcode field position [7:5]
  - opcode constants (OP_LW=3'b000, OP_SW=3'b001, OP_ADD=3'b010, OP_ADDI=3'b011, OP_SUB=3'b100, OP_JMP=3'b101)
  - fetch FSM state enum typedef
- One sub-module: fetch_buf, a parameterised DEPTH-entry FIFO with push, pop, flush, count and head outputs.

## Test plan
- Reset, L=1, memory returns 8'h40+addr, stall=0, buffer enabled -> imem_addr 0,1,2,3 on consecutive cycles; instr 8'h40,8'h41,… with instr_pc 0,1,… from cycle 2.
- stall held high for 4 cycles -> exactly 2 entries buffered, imem_req low, pc held at 2. Release -> instr_pc 0,1,2 in order, nothing lost or duplicated.
- jump_en with jump_target=8'h10 while S_WAIT and response 2 cycles away -> response discarded; next instr_pc=8'h10, instr_valid low in between.
- jump_en in the same cycle as imem_valid, with a pop pending -> buffer empty next cycle, pc=target, that data never appears.
- pc at 8'hFE, no stall -> instr_pc FE, FF, 00, 01.
- Build without FETCH_PREFETCH_BUF_EN, L=1 -> imem_req at most every other cycle; count never exceeds 1; same instruction order as the buffered build.
